// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg -- shared constants for the multiplexed 7-segment display driver.
//
// Segment codes are active-high, bit order gfedcba (segment a = bit 0).
// MAX_DIGITS bounds the NUM_DIGITS parameter of seg_display_mux.
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;  // shown for non-BCD codes A..F
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam int MAX_DIGITS = 8;

endpackage

// File: rtl/bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg -- combinational BCD to 7-segment encoder.
//
// Ports:
//   i_bcd  in  4  BCD digit; codes A..F are not decimal and show a dash
//   o_seg  out 7  active-high segment pattern, gfedcba (a = bit 0)
// -----------------------------------------------------------------------------
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // NOTE: every output of an always_comb block gets a value before any branch;
  // otherwise an uncovered path holds its old value and a latch is inferred.
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// -----------------------------------------------------------------------------
// seg_display_mux -- time-multiplexed driver for a NUM_DIGITS BCD 7-segment
// display with optional leading-zero blanking and optional blinking.
//
// Parameters:
//   NUM_DIGITS   digits scanned (1..8)
//   SCAN_DIV     clock cycles each digit stays selected (>= 2)
//   BLINK_FRAMES full scan frames per blink half-period (>= 1)
//
// Ports:
//   clk         in  1             system clock, rising edge
//   rst_n       in  1             asynchronous active-low reset
//   digits_bcd  in  4*NUM_DIGITS  packed BCD digits, digit 0 (units) in [3:0]
//   load        in  1             capture digits_bcd into the shadow register
//   blank_lead  in  1             blank leading zeros (digit 0 never blanked)
//   blink_en    in  1             blink the whole display
//   segments    out 7             registered segment pattern, gfedcba
//   digit_sel   out NUM_DIGITS    registered one-hot digit enable
//   frame_done  out 1             one-cycle pulse when the scan wraps to digit 0
//
// Build option:
//   SEG_BLINK_EN  when defined, builds the blink counter and honours blink_en;
//                 when undefined, blink_en is ignored and nothing blinks.
// -----------------------------------------------------------------------------
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic                    load,
  input  logic                    blank_lead,
  input  logic                    blink_en,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
    $error("seg_display_mux: NUM_DIGITS must be 1..%0d", MAX_DIGITS);
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg_display_mux: SCAN_DIV must be >= 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
    $error("seg_display_mux: BLINK_FRAMES must be >= 1");
  end

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [SCAN_W-1:0]       r_scan_cnt;
  logic [IDX_W-1:0]        r_index;
  logic [6:0]              r_segments;
  logic [NUM_DIGITS-1:0]   r_digit_sel;
  logic                    r_frame_done;

  logic                    w_scan_wrap;
  logic                    w_frame_wrap;
  logic [3:0]              w_digit;
  logic [6:0]              w_seg_code;
  logic [NUM_DIGITS-1:0]   w_sel_onehot;
  logic                    w_blank_digit;
  logic                    w_blink_off;

  // ---------------------------------------------------------------------------
  // Shadow register: the display shows a stable copy, not the live input.
  // ---------------------------------------------------------------------------
  // NOTE: the shadow register is reset like any other state so a display
  // powered up before the first load shows zeros rather than garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (load) begin
      r_shadow <= digits_bcd;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan timing: dwell counter and digit index.
  // ---------------------------------------------------------------------------
  assign w_scan_wrap  = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign w_frame_wrap = w_scan_wrap && (r_index == IDX_W'(NUM_DIGITS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_index    <= '0;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_index    <= w_frame_wrap ? '0 : r_index + IDX_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Digit mux, one-hot select and leading-zero detection.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_digit      = 4'h0;
    w_sel_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_index == IDX_W'(i)) begin
        w_digit         = r_shadow[4*i +: 4];
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero while
  // it and everything above it are zero. Digit 0 is never examined.
  always_comb begin
    logic zeros_above;
    zeros_above   = 1'b1;
    w_blank_digit = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeros_above = zeros_above && (r_shadow[4*i +: 4] == 4'h0);
      if (zeros_above && (r_index == IDX_W'(i))) begin
        w_blank_digit = 1'b1;
      end
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_digit),
    .o_seg (w_seg_code)
  );

  // ---------------------------------------------------------------------------
  // Blink control.
  // ---------------------------------------------------------------------------
`ifdef SEG_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;

  // Frames are counted on the wrap event itself, i.e. the same edge that
  // raises frame_done. Dropping blink_en restarts the blink from the on phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (!blink_en) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_wrap) begin
      if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign w_blink_off = blink_en && r_blink_phase;
`else
  logic w_unused_blink_en;
  assign w_unused_blink_en = blink_en;
  assign w_blink_off       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output registers: select and pattern leave together, one cycle after the
  // index they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_segments   <= SEG_OFF;
      r_digit_sel  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_digit_sel  <= w_sel_onehot;
      r_frame_done <= w_frame_wrap;
      if (w_blink_off || (blank_lead && w_blank_digit)) begin
        r_segments <= SEG_OFF;
      end else begin
        r_segments <= w_seg_code;
      end
    end
  end

  assign segments   = r_segments;
  assign digit_sel  = r_digit_sel;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_display_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_display_mux -- self-checking bench for seg_display_mux with
// NUM_DIGITS=3, SCAN_DIV=4, BLINK_FRAMES=2.
//
// A reference model derives every output from the number of clock edges since
// reset, the loaded digits and the number of frames seen while blinking is on.
// Directed phases pin the model with literal patterns; a random phase follows.
// -----------------------------------------------------------------------------
module tb_seg_display_mux;

  localparam int ND  = 3;
  localparam int SD  = 4;
  localparam int BF  = 2;
  localparam int FRAME = ND * SD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4*ND-1:0] digits_bcd = '0;
  logic            load = 1'b0;
  logic            blank_lead = 1'b0;
  logic            blink_en = 1'b0;
  logic [6:0]      segments;
  logic [ND-1:0]   digit_sel;
  logic            frame_done;

  int n_checks = 0;
  int n_errors = 0;

  seg_display_mux #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_bcd (digits_bcd),
    .load       (load),
    .blank_lead (blank_lead),
    .blink_en   (blink_en),
    .segments   (segments),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d < 4'd10) ? tbl[d] : 7'h40;
  endfunction

  int            m_edges;        // rising edges since reset released
  int            m_blink_frames; // frames completed while blink_en stayed high
  logic [4*ND-1:0] m_shadow;
  logic [6:0]    e_seg;
  logic [ND-1:0] e_sel;
  logic          e_fd;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_edges        = 0;
      m_blink_frames = 0;
      m_shadow       = '0;
      e_seg          = 7'h00;
      e_sel          = '0;
      e_fd           = 1'b0;
    end else begin
      int idx;
      logic [4*ND-1:0] upper;
      idx   = (m_edges / SD) % ND;
      upper = m_shadow >> (4 * idx);
      e_seg = encode(upper[3:0]);
      if (blank_lead && idx > 0 && upper == '0) e_seg = 7'h00;
`ifdef SEG_BLINK_EN
      if (blink_en && ((m_blink_frames / BF) % 2) == 1) e_seg = 7'h00;
`endif
      e_sel = ND'(1) << idx;
      m_edges++;
      e_fd = (m_edges % FRAME) == 0;
      if (!blink_en) m_blink_frames = 0;
      else if (e_fd) m_blink_frames++;
      if (load) m_shadow = digits_bcd;
    end
    #1;
    check("model_segments", {25'd0, segments}, {25'd0, e_seg});
    check("model_digit_sel", {29'd0, digit_sel}, {29'd0, e_sel});
    check("model_frame_done", {31'd0, frame_done}, {31'd0, e_fd});
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [4*ND-1:0] value);
    @(negedge clk);
    digits_bcd = value;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Return at the negedge right after digit_sel becomes `want`.
  task automatic wait_sel_start(input logic [ND-1:0] want, output bit found);
    logic [ND-1:0] prev;
    prev  = digit_sel;
    found = 1'b0;
    for (int n = 0; n < 4 * FRAME && !found; n++) begin
      @(negedge clk);
      if (digit_sel == want && prev != want) found = 1'b1;
      prev = digit_sel;
    end
    if (!found) timeout_fail("wait_digit_sel");
  endtask

  task automatic check_frame(input string name, input logic [6:0] s0,
                             input logic [6:0] s1, input logic [6:0] s2);
    bit found;
    logic [6:0] pat [3];
    pat = '{s0, s1, s2};
    wait_sel_start(3'b001, found);
    if (found) begin
      for (int k = 0; k < FRAME; k++) begin
        check({name, "_sel"}, {29'd0, digit_sel}, {29'd0, 3'b001 << (k / SD)});
        check({name, "_seg"}, {25'd0, segments}, {25'd0, pat[k / SD]});
        if (k != FRAME - 1) @(negedge clk);
      end
    end
  endtask

  task automatic wait_frame_done(output bit found);
    found = 1'b0;
    for (int n = 0; n < 4 * FRAME && !found; n++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    if (!found) timeout_fail("wait_frame_done");
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit found;
    int n;
    int zeros_a;
    int zeros_b;

    // Reset state
    #2;
    check("reset_segments", {25'd0, segments}, 32'h0);
    check("reset_digit_sel", {29'd0, digit_sel}, 32'h0);
    check("reset_frame_done", {31'd0, frame_done}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_sel", {29'd0, digit_sel}, 32'h1);
    check("first_edge_seg", {25'd0, segments}, 32'h3F);

    // Basic scan and frame period
    do_load(12'h159);
    check_frame("scan_159", 7'h6F, 7'h6D, 7'h06);
    wait_frame_done(found);
    if (found) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!frame_done && n < 4 * FRAME);
      check("frame_period", n, FRAME);
    end

    // Leading-zero blanking
    blank_lead = 1'b1;
    do_load(12'h007);
    check_frame("blank_007", 7'h07, 7'h00, 7'h00);
    do_load(12'h000);
    check_frame("blank_000", 7'h3F, 7'h00, 7'h00);
    do_load(12'h105);
    check_frame("blank_105", 7'h6D, 7'h3F, 7'h06);

    // Non-BCD code
    blank_lead = 1'b0;
    do_load(12'h0A0);
    check_frame("dash_0a0", 7'h3F, 7'h40, 7'h3F);
    blank_lead = 1'b1;
    check_frame("dash_0a0_blank", 7'h3F, 7'h40, 7'h00);
    blank_lead = 1'b0;

    // Blink: start right after a frame boundary
    do_load(12'h159);
    wait_frame_done(found);
    blink_en = 1'b1;
    zeros_a = 0;
    zeros_b = 0;
    for (int k = 0; k < 2 * BF * FRAME; k++) begin
      @(negedge clk);
      if (segments == 7'h00) begin
        if (k < BF * FRAME) zeros_a++;
        else zeros_b++;
      end
    end
    check("blink_on_half_zeros", zeros_a, 0);
`ifdef SEG_BLINK_EN
    check("blink_off_half_zeros", zeros_b, BF * FRAME);
`else
    check("blink_off_half_zeros", zeros_b, 0);
`endif
    blink_en = 1'b0;
    zeros_a = 0;
    for (int k = 0; k < BF * FRAME; k++) begin
      @(negedge clk);
      if (segments == 7'h00) zeros_a++;
    end
    check("blink_disabled_zeros", zeros_a, 0);

    // Load latency while digit 0 is selected: the load is presented for one
    // cycle; the pattern changes at the second rising edge.
    do_load(12'h123);
    wait_sel_start(3'b001, found);
    if (found) begin
      digits_bcd = 12'h999;
      load       = 1'b1;
      @(posedge clk);
      #1;
      check("load_latency_edge1", {25'd0, segments}, 32'h4F);
      @(negedge clk);
      load = 1'b0;
      @(posedge clk);
      #1;
      check("load_latency_edge2", {25'd0, segments}, 32'h6F);
    end

    // Asynchronous reset while digit 1 is selected
    wait_sel_start(3'b010, found);
    if (found) begin
      check("pre_reset_seg", {25'd0, segments}, 32'h6F);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_seg", {25'd0, segments}, 32'h0);
      check("async_reset_sel", {29'd0, digit_sel}, 32'h0);
      check("async_reset_fd", {31'd0, frame_done}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_sel", {29'd0, digit_sel}, 32'h1);
      check("post_reset_seg", {25'd0, segments}, 32'h3F);
    end

    // Random phase, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(699) == 0) rst_n = 1'b0;
      load = ($urandom_range(7) == 0);
      for (int d = 0; d < ND; d++) begin
        digits_bcd[4*d +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
      end
      if ($urandom_range(49) == 0) blank_lead = ~blank_lead;
      if ($urandom_range(99) == 0) blink_en = ~blink_en;
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
